pwm_actuator_driver: RTL
========================

Name: pwm_actuator_driver

Overview:
Downstream stage of the PID controller. Consumes the 8-bit control_signal and converts it into a complementary PWM pair (high-side / low-side) for an H-bridge leg. Adds per-period slew limiting, dead-time insertion and a sticky emergency-stop fault latch. Sits between the controller core and the pads.

Parameters:
WIDTH, 8, bit width of control_signal, duty and the period counter; the period is 2^WIDTH ticks.
SLEW_STEP, 4, maximum change of applied duty per PWM period; must be >= 1.
DEAD_TIME, 2, clk cycles during which both outputs are held low at every transition; must be >= 1.
PRESCALE, 1, clk cycles per PWM tick; must be >= 1.

Ports:
clk  input  1  single system clock, all logic on rising edge.
rst  input  1  asynchronous, active-high reset.
enable  input  1  run request; low forces the idle state.
estop  input  1  emergency stop; sets the sticky fault.
control_signal  input  WIDTH  target duty from the PID controller.
duty  output  WIDTH  currently applied duty, registered.
pwm_hi  output  1  high-side gate drive, registered.
pwm_lo  output  1  low-side gate drive, registered.
period_start  output  1  one-cycle pulse when the counter wraps and duty updates.
fault  output  1  sticky estop fault flag.

Behaviour:
- Reset (async, any time, including mid-period): counter=0, prescaler=0, duty=0, state IDLE, pwm_hi=pwm_lo=0, period_start=0, fault=0.
- Tick: the prescaler counts 0..PRESCALE-1. The counter advances on the prescaler's last cycle and wraps from 2^WIDTH-1 to 0.
- Wrap cycle:
  - control_signal is sampled.
  - Slew is computed in WIDTH+1 bits, with no wrap:
    - if target > duty+SLEW_STEP, then duty += SLEW_STEP;
    - else if target + SLEW_STEP < duty, then duty -= SLEW_STEP;
    - else duty = target.
  - New duty is effective from counter=0.
  - period_start pulses in the same cycle the counter becomes 0.
- raw = (counter < duty).
  - duty=0: raw is always 0.
  - duty=2^WIDTH-1: raw is low for 1 tick per period.
- Output FSM, one state register; outputs are decoded from the state and registered:
  - IDLE: hi=0, lo=0. Leave to LO when enable=1 and fault=0.
  - LO: lo=1. On raw=1, go to DT_H and load the dead-time counter with DEAD_TIME.
  - DT_H: both outputs 0; the counter decrements each clk. At 0 go to HI. If raw falls first, go to LO (the pulse is swallowed).
  - HI: hi=1. On raw=0, go to DT_L.
  - DT_L: both outputs 0. At 0 go to LO. If raw rises first, go to HI.
  - Never hi=1 and lo=1 simultaneously; this is an assertion in the bench.
- enable=0:
  - Next cycle the state is IDLE.
  - counter, prescaler and duty clear to 0 and are held.
  - fault clears.
  - Re-enable soft-starts the ramp from duty 0.
- estop=1 (sampled): fault is set, and the next cycle the state is IDLE with both outputs 0 and duty cleared.
  - fault holds after estop is released, until enable=0 or rst.
  - estop has priority over enable.
- Simultaneous wrap and transition: the FSM uses raw computed from the post-update counter and duty.

Decomposition:
- Shared package pid_pkg: WIDTH default, the FSM state enum (IDLE, LO, DT_H, HI, DT_L), and the slew-compute function.
- One sub-module, pwm_deadtime_fsm: takes raw, enable and fault, and produces pwm_hi/pwm_lo.
- Counter, prescaler and slew logic stay in the top.

Test Plan:
(Defaults unless stated.)
1. Reset: assert rst mid-HI with duty=64 -> the same cycle all outputs are 0. Release -> duty=0, state IDLE, no period_start.
2. Upward slew: enable, control=20 -> duty on successive period_start pulses is 4, 8, 12, 16, 20, then holds 20.
3. Downward and snap: duty=20. Set control=18 -> duty=18 next period. Set control=0 -> 14, 10, 6, 2, 0.
4. Dead time at duty=64:
   - per period, pwm_hi is high 62 cycles and pwm_lo is high 190 cycles;
   - both are low for exactly 2 cycles at each edge;
   - hi and lo are never high together.
5. Short pulse: duty=1 -> pwm_hi never asserts. With PRESCALE=4, duty=1 -> pwm_hi is high 2 cycles per period.
6. Estop:
   - pulse estop for 1 cycle during HI -> the next cycle hi=lo=0, fault=1, duty=0;
   - it stays idle after estop drops;
   - enable low then high -> fault=0 and the ramp restarts at 4.

Source files
------------

// File: rtl/pid_pkg.sv
// Shared definitions for the PID actuator path: default width, output FSM states
// and the per-period duty slew rule.
package pid_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE,
        LO,
        DT_H,
        HI,
        DT_L
    } pwm_state_e;

    // Evaluated one bit wider than the operands so duty +/- step can never wrap.
    function automatic logic [31:0] slew_next(input logic [31:0] cur,
                                              input logic [31:0] tgt,
                                              input logic [31:0] step);
        logic [32:0] cur_w;
        logic [32:0] tgt_w;
        logic [32:0] step_w;
        cur_w = {1'b0, cur};
        tgt_w = {1'b0, tgt};
        step_w = {1'b0, step};
        if (tgt_w > cur_w + step_w) begin
            slew_next = cur + step;
        end else if (tgt_w + step_w < cur_w) begin
            slew_next = cur - step;
        end else begin
            slew_next = tgt;
        end
    endfunction

endpackage

// File: rtl/pwm_deadtime_fsm.sv
// Complementary gate-drive sequencer: turns the raw PWM level into hi/lo drives
// with a dead band on every edge; outputs are registered alongside the state.
module pwm_deadtime_fsm
    import pid_pkg::*;
#(
    parameter int unsigned DEAD_TIME = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    input  logic enable_i,
    input  logic fault_i,
    output logic pwm_hi_o,
    output logic pwm_lo_o
);

    localparam int unsigned DT_W = $clog2(DEAD_TIME + 1);

    pwm_state_e      state_q;
    logic [DT_W-1:0] dt_q;
    logic            hi_q;
    logic            lo_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dt_q    <= '0;
            hi_q    <= 1'b0;
            lo_q    <= 1'b0;
        end else if (!enable_i || fault_i) begin
            state_q <= IDLE;
            dt_q    <= '0;
            hi_q    <= 1'b0;
            lo_q    <= 1'b0;
        end else begin
            hi_q <= 1'b0;
            lo_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    state_q <= LO;
                    lo_q    <= 1'b1;
                end
                LO: begin
                    if (raw_i) begin
                        state_q <= DT_H;
                        dt_q    <= DT_W'(DEAD_TIME);
                    end else begin
                        lo_q <= 1'b1;
                    end
                end
                // A pulse narrower than the dead band is swallowed here.
                DT_H: begin
                    if (!raw_i) begin
                        state_q <= LO;
                        lo_q    <= 1'b1;
                    end else if (dt_q <= DT_W'(1)) begin
                        state_q <= HI;
                        hi_q    <= 1'b1;
                    end else begin
                        dt_q <= dt_q - DT_W'(1);
                    end
                end
                HI: begin
                    if (!raw_i) begin
                        state_q <= DT_L;
                        dt_q    <= DT_W'(DEAD_TIME);
                    end else begin
                        hi_q <= 1'b1;
                    end
                end
                DT_L: begin
                    if (raw_i) begin
                        state_q <= HI;
                        hi_q    <= 1'b1;
                    end else if (dt_q <= DT_W'(1)) begin
                        state_q <= LO;
                        lo_q    <= 1'b1;
                    end else begin
                        dt_q <= dt_q - DT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign pwm_hi_o = hi_q;
    assign pwm_lo_o = lo_q;

endmodule

// File: rtl/pwm_actuator_driver.sv
// PWM actuator driver: prescaled period counter, slew-limited duty update on wrap,
// sticky estop fault, and a dead-time sequenced complementary output pair.
module pwm_actuator_driver
    import pid_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEFAULT,
    parameter int unsigned SLEW_STEP = 4,
    parameter int unsigned DEAD_TIME = 2,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             estop,
    input  logic [WIDTH-1:0] control_signal,
    output logic [WIDTH-1:0] duty,
    output logic             pwm_hi,
    output logic             pwm_lo,
    output logic             period_start,
    output logic             fault
);

    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0]  presc_q;
    logic [PS_W-1:0]  presc_d;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] duty_q;
    logic [WIDTH-1:0] duty_d;
    logic             ps_q;
    logic             ps_d;
    logic             fault_q;
    logic             fault_d;
    logic             run_c;
    logic             tick_c;
    logic             wrap_c;
    logic             raw_c;
    logic             fault_c;

    // Period counter, duty slew and fault latch; anything but a clean run holds all at zero.
    always_comb begin
        run_c   = enable & ~estop & ~fault_q;
        tick_c  = (presc_q == PS_W'(PRESCALE - 1));
        wrap_c  = tick_c && (cnt_q == {WIDTH{1'b1}});
        presc_d = presc_q;
        cnt_d   = cnt_q;
        duty_d  = duty_q;
        ps_d    = 1'b0;
        fault_d = fault_q;
        if (estop) begin
            fault_d = 1'b1;
        end else if (!enable) begin
            fault_d = 1'b0;
        end
        if (!run_c) begin
            presc_d = '0;
            cnt_d   = '0;
            duty_d  = '0;
        end else begin
            presc_d = tick_c ? '0 : presc_q + PS_W'(1);
            if (tick_c) begin
                cnt_d = cnt_q + WIDTH'(1);
            end
            if (wrap_c) begin
                duty_d = WIDTH'(slew_next(32'(duty_q), 32'(control_signal), 32'(SLEW_STEP)));
                ps_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            cnt_q   <= '0;
            duty_q  <= '0;
            ps_q    <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            duty_q  <= duty_d;
            ps_q    <= ps_d;
            fault_q <= fault_d;
        end
    end

    // Raw level uses the registered counter and duty, so a fresh duty applies from count 0.
    assign raw_c   = (cnt_q < duty_q);
    assign fault_c = estop | fault_q;

    pwm_deadtime_fsm #(
        .DEAD_TIME(DEAD_TIME)
    ) u_fsm (
        .clk     (clk),
        .rst     (rst),
        .raw_i   (raw_c),
        .enable_i(enable),
        .fault_i (fault_c),
        .pwm_hi_o(pwm_hi),
        .pwm_lo_o(pwm_lo)
    );

    assign duty         = duty_q;
    assign period_start = ps_q;
    assign fault        = fault_q;

endmodule
